// File: rtl/pluto_log_pkg.sv
// Shared types for the PLUTO event logger: event codes, record layout, helpers.
// Optional timestamp field is enabled by defining PLUTO_LOG_TIMESTAMP_EN.
package pluto_log_pkg;

   typedef enum logic [2:0] {
      EV_PLUTO0 = 3'd0,
      EV_PLUTO1 = 3'd1,
      EV_PLUTO2 = 3'd2,
      EV_PLUTO3 = 3'd3,
      EV_PLUTO4 = 3'd4,
      EV_PLUTO5 = 3'd5,
      EV_VERR   = 3'd6,
      EV_OWL    = 3'd7
   } ev_code_e;

   localparam int unsigned NUM_EV = 8;

`ifdef PLUTO_LOG_TIMESTAMP_EN
   localparam int unsigned TS_W  = 16;
   localparam int unsigned REC_W = 20;

   typedef struct packed {
      logic [TS_W-1:0] ts;
      logic            sdo;
      ev_code_e        code;
   } rec_t;
`else
   localparam int unsigned REC_W = 4;

   typedef struct packed {
      logic     sdo;
      ev_code_e code;
   } rec_t;
`endif

   // Index of the lowest set bit; 0 when none is set.
   function automatic logic [2:0] lowest_set(input logic [NUM_EV-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = int'(NUM_EV) - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pluto_log_fifo.sv
// Record FIFO with wrap-bit pointers; simultaneous push and pop succeed even when full.
module pluto_log_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned REC_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [REC_W-1:0] push_data,
   input  logic             pop,
   output logic [REC_W-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [REC_W-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty & ~clr;
   // When full, the write slot is the head slot being popped this same cycle.
   assign do_push = push & ~clr & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pluto_event_logger.sv
// Logs controller flag edges as coded records in a FIFO with per-event saturating counters.
// Define PLUTO_LOG_TIMESTAMP_EN to add a 16-bit cycle timestamp to each record.
module pluto_event_logger
   import pluto_log_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       pluto,
   input  logic             verr_f,
   input  logic             owl_f,
   input  logic             sdo,
   input  logic             clr,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [REC_W-1:0] rec_data,
   input  logic [2:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_val,
   output logic [7:0]       drop_cnt
);

   logic [5:0]        pluto_prev;
   logic              verr_prev;
   logic              owl_prev;
   logic [NUM_EV-1:0] pending, pending_n;
   logic [NUM_EV-1:0] sdo_pend, sdo_pend_n;
   logic [CNT_W-1:0]  counters [NUM_EV];
   logic [CNT_W-1:0]  cnt_n    [NUM_EV];
   logic [7:0]        drop_n;

   logic [NUM_EV-1:0] ev;
   logic [2:0]        push_idx;
   logic              push_req;
   logic              pop_acc;
   logic              drop;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   rec_t              push_rec;
   logic [REC_W-1:0]  head_data;

`ifdef PLUTO_LOG_TIMESTAMP_EN
   logic [TS_W-1:0]   ts, ts_n;
   logic [TS_W-1:0]   ts_pend   [NUM_EV];
   logic [TS_W-1:0]   ts_pend_n [NUM_EV];
`endif

   // Edge detection, push arbitration and next-state for counters/pending.
   always_comb begin
      ev        = {owl_prev & ~owl_f, verr_prev & ~verr_f, pluto & ~pluto_prev};
      push_idx  = lowest_set(pending);
      push_req  = (|pending) & ~clr;
      pop_acc   = rec_ready & ~fifo_empty & ~clr;
      drop      = push_req & fifo_full & ~pop_acc;
      fifo_push = push_req & ~drop;

      push_rec      = '0;
      push_rec.code = ev_code_e'(push_idx);
      push_rec.sdo  = sdo_pend[push_idx];
`ifdef PLUTO_LOG_TIMESTAMP_EN
      push_rec.ts   = ts_pend[push_idx];
`endif

      // A same-code edge in the push cycle re-arms the bit after it is cleared.
      pending_n = pending;
      if (push_req) pending_n[push_idx] = 1'b0;
      pending_n = pending_n | ev;

      sdo_pend_n = sdo_pend;
      for (int i = 0; i < int'(NUM_EV); i++) begin
         if (ev[i]) sdo_pend_n[i] = sdo;
         cnt_n[i] = (ev[i] && (counters[i] != '1)) ? counters[i] + CNT_W'(1) : counters[i];
      end

      drop_n = (drop && (drop_cnt != 8'hFF)) ? drop_cnt + 8'd1 : drop_cnt;

`ifdef PLUTO_LOG_TIMESTAMP_EN
      ts_n = ts + TS_W'(1);
      for (int i = 0; i < int'(NUM_EV); i++) begin
         ts_pend_n[i] = ev[i] ? ts : ts_pend[i];
      end
`endif

      // Soft clear wins over everything; edges seen this cycle are dropped.
      if (clr) begin
         pending_n = '0;
         drop_n    = 8'd0;
         for (int i = 0; i < int'(NUM_EV); i++) cnt_n[i] = '0;
`ifdef PLUTO_LOG_TIMESTAMP_EN
         ts_n = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pluto_prev <= 6'd0;
         verr_prev  <= 1'b1;
         owl_prev   <= 1'b1;
         pending    <= '0;
         sdo_pend   <= '0;
         drop_cnt   <= 8'd0;
         cnt_val    <= '0;
         for (int i = 0; i < int'(NUM_EV); i++) counters[i] <= '0;
`ifdef PLUTO_LOG_TIMESTAMP_EN
         ts <= '0;
         for (int i = 0; i < int'(NUM_EV); i++) ts_pend[i] <= '0;
`endif
      end else begin
         pluto_prev <= pluto;
         verr_prev  <= verr_f;
         owl_prev   <= owl_f;
         pending    <= pending_n;
         sdo_pend   <= sdo_pend_n;
         drop_cnt   <= drop_n;
         cnt_val    <= counters[cnt_sel];
         for (int i = 0; i < int'(NUM_EV); i++) counters[i] <= cnt_n[i];
`ifdef PLUTO_LOG_TIMESTAMP_EN
         ts <= ts_n;
         for (int i = 0; i < int'(NUM_EV); i++) ts_pend[i] <= ts_pend_n[i];
`endif
      end
   end

   pluto_log_fifo #(
      .DEPTH (DEPTH),
      .REC_W (REC_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (fifo_push),
      .push_data (REC_W'(push_rec)),
      .pop       (pop_acc),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rec_valid = ~fifo_empty;
   assign rec_data  = head_data;

endmodule

// File: tb/tb_pluto_event_logger.sv
// Scoreboard bench for pluto_event_logger: stimulus enqueues expected records,
// a negedge monitor pops and compares them on every accepted handshake.
module tb_pluto_event_logger;
   import pluto_log_pkg::*;

   logic             clk;
   logic             rst_n;
   logic [5:0]       pluto;
   logic             verr_f;
   logic             owl_f;
   logic             sdo;
   logic             clr;
   logic             rec_valid;
   logic             rec_ready;
   logic [REC_W-1:0] rec_data;
   logic [2:0]       cnt_sel;
   logic [7:0]       cnt_val;
   logic [7:0]       drop_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pops   = 0;
   logic [3:0] exp_q [$];
   int         pop_cyc [$];

   pluto_event_logger #(.DEPTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pluto     (pluto),
      .verr_f    (verr_f),
      .owl_f     (owl_f),
      .sdo       (sdo),
      .clr       (clr),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_data  (rec_data),
      .cnt_sel   (cnt_sel),
      .cnt_val   (cnt_val),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] mk(input logic s, input logic [2:0] code);
      return {s, code};
   endfunction

   // Monitor: every accepted record must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && rec_valid && rec_ready) begin
         pops++;
         pop_cyc.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: got %0h expected none", rec_data[3:0]);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (rec_data[3:0] !== e) begin
               errors++;
               $display("FAIL record: got %0h expected %0h", rec_data[3:0], e);
            end
         end
      end
   end

   task automatic drain(input string name);
      int n;
      n = 0;
      rec_ready = 1'b1;
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
      rec_ready = 1'b0;
   endtask

   task automatic pulse_event(input int code, input logic s, input bit expect_rec);
      sdo = s;
      if (code < 6) pluto[code] = 1'b1;
      else if (code == 6) verr_f = 1'b0;
      else owl_f = 1'b0;
      if (expect_rec) exp_q.push_back(mk(s, 3'(code)));
      tick();
      pluto  = 6'd0;
      verr_f = 1'b1;
      owl_f  = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; pluto = 6'd0; verr_f = 1'b1; owl_f = 1'b1; sdo = 1'b0;
      clr = 1'b0; rec_ready = 1'b0; cnt_sel = 3'd0;
      tick(); tick();
      check("reset_rec_valid", 32'(rec_valid), 32'd0);
      check("reset_rec_data", 32'(rec_data), 32'd0);
      check("reset_cnt_val", 32'(cnt_val), 32'd0);
      check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      tick();
      check("no_event_after_reset", 32'(rec_valid), 32'd0);

      // Single held edge: one record, 2-cycle latency, counter 1.
      pluto = 6'b000001; sdo = 1'b1;
      exp_q.push_back(mk(1'b1, 3'd0));
      tick();
      check("latency_edge_k", 32'(rec_valid), 32'd0);
      tick();
      check("latency_edge_k1", 32'(rec_valid), 32'd1);
      check("cnt0_after_one", 32'(cnt_val), 32'd1);
      tick();
      pluto = 6'd0;
      tick();
      check("held_valid_stable", 32'(rec_data), 32'(mk(1'b1, 3'd0)));
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      check("exactly_one_record", 32'(rec_valid), 32'd0);

      // Two simultaneous edges pop on consecutive cycles, lowest code first.
      pop_cyc.delete();
      rec_ready = 1'b1; sdo = 1'b0;
      pluto = 6'b100100;
      exp_q.push_back(mk(1'b0, 3'd2));
      exp_q.push_back(mk(1'b0, 3'd5));
      tick();
      pluto = 6'd0;
      repeat (4) tick();
      rec_ready = 1'b0;
      check("dual_pop_count", 32'(pop_cyc.size()), 32'd2);
      if (pop_cyc.size() == 2) check("dual_pop_consecutive", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("dual_queue_empty", 32'(exp_q.size()), 32'd0);

      // Ten distinct events into an 8-deep FIFO with no consumer.
      clr = 1'b1; tick(); clr = 1'b0;
      for (int e = 0; e < 10; e++) pulse_event((e < 8) ? e : e - 8, 1'(e), e < 8);
      check("overflow_drop_cnt", 32'(drop_cnt), 32'd2);
      check("overflow_valid", 32'(rec_valid), 32'd1);
      for (int s = 0; s < 8; s++) begin
         cnt_sel = 3'(s);
         tick();
         check($sformatf("overflow_cnt%0d", s), 32'(cnt_val), (s < 2) ? 32'd2 : 32'd1);
      end

      // Full FIFO: push and pop in the same cycle, nothing dropped.
      pluto[2] = 1'b1; sdo = 1'b1;
      exp_q.push_back(mk(1'b1, 3'd2));
      tick();
      pluto = 6'd0;
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      check("full_pushpop_drop_cnt", 32'(drop_cnt), 32'd2);
      pops = 0;
      drain("full");
      check("full_remained_full", 32'(pops), 32'd8);
      check("full_empty_after_drain", 32'(rec_valid), 32'd0);

      // Counter saturation, then soft clear.
      clr = 1'b1; tick(); clr = 1'b0;
      cnt_sel = 3'd3; rec_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         pluto[3] = 1'b1; sdo = 1'(i);
         exp_q.push_back(mk(1'(i), 3'd3));
         tick();
         pluto[3] = 1'b0;
         tick();
      end
      tick();
      check("cnt3_saturated", 32'(cnt_val), 32'd255);
      drain("sat");
      clr = 1'b1; tick(); clr = 1'b0;
      tick();
      check("cnt3_after_clr", 32'(cnt_val), 32'd0);
      check("drop_after_clr", 32'(drop_cnt), 32'd0);

      // Reset with records buffered discards them.
      pluto = 6'b010010; sdo = 1'b0;
      exp_q.push_back(mk(1'b0, 3'd1));
      exp_q.push_back(mk(1'b0, 3'd4));
      tick(); pluto = 6'd0; tick(); tick();
      check("buffered_before_reset", 32'(rec_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      check("midreset_rec_valid", 32'(rec_valid), 32'd0);
      check("midreset_rec_data", 32'(rec_data), 32'd0);
      check("midreset_cnt_val", 32'(cnt_val), 32'd0);

      // verr_f fall five cycles after reset release.
      rst_n = 1'b1;
      repeat (5) tick();
      verr_f = 1'b0; sdo = 1'b1;
      exp_q.push_back(mk(1'b1, 3'd6));
      tick();
      verr_f = 1'b1;
      tick();
      check("verr_valid", 32'(rec_valid), 32'd1);
`ifdef PLUTO_LOG_TIMESTAMP_EN
      check("verr_timestamp", 32'(rec_data[19:4]), 32'd5);
`endif
      drain("verr");
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
